// File: rtl/pq_cmd_sequencer.sv
// Command front-end for the register-tree priority queue: legality check, one-cycle
// wrt/read pulses, post-operation idle gap, and one response per accepted command.
module pq_cmd_sequencer #(
   parameter int QUEUE_SIZE = 7,
   parameter int DATA_WIDTH = 16,
   parameter int ENQ_GAP    = $clog2(QUEUE_SIZE),
   parameter int DEQ_GAP    = 2
) (
   input  logic                            i_CLK,
   input  logic                            i_RST,
   input  logic                            i_cmd_valid,
   output logic                            o_cmd_ready,
   input  logic [1:0]                      i_cmd_op,
   input  logic [DATA_WIDTH-1:0]           i_cmd_data,
   output logic                            o_pq_wrt,
   output logic                            o_pq_read,
   output logic [DATA_WIDTH-1:0]           o_pq_data,
   input  logic                            i_pq_full,
   input  logic                            i_pq_empty,
   input  logic [DATA_WIDTH-1:0]           i_pq_data,
   output logic                            o_rsp_valid,
   input  logic                            i_rsp_ready,
   output logic [DATA_WIDTH-1:0]           o_rsp_data,
   output logic [1:0]                      o_rsp_status,
   output logic [$clog2(QUEUE_SIZE+1)-1:0] o_count
);
   localparam int CW   = $clog2(QUEUE_SIZE+1);
   localparam int GMAX = (ENQ_GAP > DEQ_GAP) ? ENQ_GAP : DEQ_GAP;
   localparam int GW   = $clog2(GMAX+1) < 1 ? 1 : $clog2(GMAX+1);

   localparam logic [1:0] OP_ENQ = 2'b00, OP_DEQ = 2'b01, OP_REP = 2'b10;
   localparam logic [1:0] ST_OK = 2'b00, ST_FULL = 2'b01, ST_EMPTY = 2'b10, ST_ILL = 2'b11;

   typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

   state_t          state, state_nxt;
   logic [GW-1:0]   gap_cnt;
   logic            accept, legal;
   logic [1:0]      status;

   assign accept = i_cmd_valid && o_cmd_ready;
   assign legal  = (status == ST_OK);

   always_comb begin
      status = ST_OK;
      case (i_cmd_op)
         OP_ENQ:         if (i_pq_full)  status = ST_FULL;
         OP_DEQ, OP_REP: if (i_pq_empty) status = ST_EMPTY;
         default:        status = ST_ILL;
      endcase
   end

   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) state <= IDLE;
      else       state <= state_nxt;
   end

   // Gap counter holds its loaded value through PULSE, so a zero gap skips GAP entirely.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept && legal) state_nxt = PULSE;
         PULSE:   state_nxt = (gap_cnt == '0) ? IDLE : GAP;
         GAP:     if (gap_cnt <= GW'(1)) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      o_cmd_ready = !i_RST && (state == IDLE) && !o_rsp_valid;
   end

   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         gap_cnt      <= '0;
         o_pq_wrt     <= 1'b0;
         o_pq_read    <= 1'b0;
         o_pq_data    <= '0;
         o_rsp_valid  <= 1'b0;
         o_rsp_data   <= '0;
         o_rsp_status <= ST_OK;
         o_count      <= '0;
      end else begin
         o_pq_wrt  <= 1'b0;
         o_pq_read <= 1'b0;
         if (state == GAP && gap_cnt != '0) gap_cnt <= gap_cnt - GW'(1);

         if (accept) begin
            o_rsp_valid  <= 1'b1;
            o_rsp_status <= status;
            o_rsp_data   <= (legal && i_cmd_op != OP_ENQ) ? i_pq_data : '0;
            if (legal) begin
               o_pq_wrt  <= (i_cmd_op != OP_DEQ);
               o_pq_read <= (i_cmd_op != OP_ENQ);
               o_pq_data <= i_cmd_data;
               gap_cnt   <= (i_cmd_op == OP_ENQ) ? GW'(ENQ_GAP) : GW'(DEQ_GAP);
               if (i_cmd_op == OP_ENQ && o_count != CW'(QUEUE_SIZE)) o_count <= o_count + CW'(1);
               if (i_cmd_op == OP_DEQ && o_count != '0)              o_count <= o_count - CW'(1);
            end
         end else if (o_rsp_valid && i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
         end
      end
   end
endmodule

// File: doc/pq_cmd_sequencer.md
Name: pq_cmd_sequencer

Overview:
- Front-end stage directly upstream of register_tree (the register-tree priority queue, QUEUE_SIZE entries, max at root).
- Accepts a valid/ready command stream (ENQUEUE / DEQUEUE / REPLACE), checks legality against the queue's full/empty flags, and issues single-cycle i_wrt/i_read pulses.
- Enforces the queue's mandatory idle gap after each operation and returns one response per command, carrying the popped value and a status.

Parameters:
- QUEUE_SIZE, 7, capacity of the downstream register tree.
- DATA_WIDTH, 16, payload width.
- ENQ_GAP, $clog2(QUEUE_SIZE), idle cycles required after an enqueue pulse.
- DEQ_GAP, 2, idle cycles required after a dequeue or replace pulse.

Ports:
- i_CLK  in  1  clock
- i_RST  in  1  asynchronous active-high reset
- i_cmd_valid  in  1  command valid
- o_cmd_ready  out  1  command ready
- i_cmd_op  in  2  00 ENQUEUE, 01 DEQUEUE, 10 REPLACE, 11 reserved
- i_cmd_data  in  DATA_WIDTH  payload for ENQUEUE/REPLACE
- o_pq_wrt  out  1  write pulse to queue
- o_pq_read  out  1  read pulse to queue
- o_pq_data  out  DATA_WIDTH  data to queue
- i_pq_full  in  1  queue full flag
- i_pq_empty  in  1  queue empty flag
- i_pq_data  in  DATA_WIDTH  queue root (max) value
- o_rsp_valid  out  1  response valid
- i_rsp_ready  in  1  response ready
- o_rsp_data  out  DATA_WIDTH  value removed from the root (0 if none)
- o_rsp_status  out  2  00 OK, 01 FULL, 10 EMPTY, 11 ILLEGAL
- o_count  out  $clog2(QUEUE_SIZE+1)  shadow occupancy

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset, immediate and asynchronous, including mid-operation:
  - state IDLE, gap counter 0.
  - o_pq_wrt, o_pq_read, o_pq_data, o_rsp_valid, o_rsp_data, o_rsp_status, o_count all 0.
  - o_cmd_ready 0 while i_RST is high.
- FSM states: IDLE, PULSE, GAP.
- o_cmd_ready = (state == IDLE) && !o_rsp_valid. This is combinational.
- Command accept: edge E where i_cmd_valid && o_cmd_ready. At E, i_pq_full, i_pq_empty and i_pq_data are sampled.
- Legality, decided at E:
  - ENQUEUE with full: status FULL.
  - DEQUEUE or REPLACE with empty: status EMPTY.
  - op 11: status ILLEGAL.
  - Anything else is legal.
- Legal command:
  - At E, register the pulses:
    - ENQUEUE: o_pq_wrt=1, o_pq_read=0.
    - DEQUEUE: o_pq_wrt=0, o_pq_read=1.
    - REPLACE: o_pq_wrt=1, o_pq_read=1.
  - At E, register o_pq_data=i_cmd_data and go to PULSE.
  - Pulses are high for exactly the one cycle after E, then cleared.
  - o_pq_data holds its value until the next legal command.
  - PULSE then GAP. The gap counter loads ENQ_GAP (ENQUEUE) or DEQ_GAP (DEQUEUE/REPLACE).
  - GAP decrements each cycle and returns to IDLE when it expires.
  - Next accept is possible no earlier than edge E+2+gap, i.e. E+5 for enqueue and E+4 for dequeue/replace at defaults.
- Illegal or rejected command: no pulse, no gap, stays in IDLE, response still produced.
- Response:
  - Registered at E; o_rsp_valid rises in the cycle after E.
  - o_rsp_data = sampled i_pq_data for OK DEQUEUE/REPLACE, else 0.
  - Response held stable until i_rsp_ready. Clears on the handshake edge.
  - Backpressure blocks new commands but never stretches or delays an issued pulse or gap.
- o_count:
  - +1 on OK ENQUEUE at E; −1 on OK DEQUEUE at E; unchanged on REPLACE and on rejects.
  - Saturates at QUEUE_SIZE and 0 (cannot exceed by construction).
- Changes to i_cmd_* while o_cmd_ready is low are ignored.
- Exactly one response per accepted command, in order.

Test Plan:
- Reset, then 7× ENQUEUE of 100,900,5,700,300,1023,50 with i_rsp_ready=1:
  - Each gets status OK, data 0, with accepts ≥5 cycles apart.
  - o_count=7. The queue root reads 1023.
- 8th ENQUEUE of 42 while full: status FULL, no o_pq_wrt pulse, o_count stays 7.
- 7× DEQUEUE: responses 1023,900,700,300,100,50,5 in that order, each OK. Then an 8th DEQUEUE returns status EMPTY with data 0 and no o_pq_read pulse.
- Fill with 10,20,30, then REPLACE 25:
  - o_pq_wrt and o_pq_read are high together for one cycle.
  - Response is OK/30, o_count stays 3, next root is 25.
- Hold i_rsp_ready=0 for 6 cycles after an ENQUEUE:
  - o_cmd_ready stays low.
  - Response is stable; pulse and gap timing are unchanged.
  - The next command is accepted on the edge after the handshake.
- Assert i_RST during the PULSE cycle of a DEQUEUE: o_pq_read drops immediately, and all outputs and o_count read 0. After release, op 11 gives status ILLEGAL.
